// File: rtl/counter_gen_pkg.sv
// counter_gen_pkg: shared types and elaboration-time helpers for counter_gen.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package counter_gen_pkg;

  // Boundary behaviour selector. MODE_RSVD decodes as saturate.
  typedef enum logic [1:0] {
    MODE_WRAP   = 2'd0,
    MODE_SAT    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // Two guard bits above the count width hold count +/- step without
  // losing the sign or the carry.
  localparam int ARITH_GUARD = 2;

  // Number of distinct values in the inclusive range [mn, mx].
  function automatic int range_of(input int mn, input int mx);
    return mx - mn + 1;
  endfunction

  // Parameter sanity: MIN < MAX fits in WIDTH bits, and the largest step
  // never exceeds the range, so a single +/-R correction is always enough.
  function automatic bit bounds_ok(input int width, input int step_w,
                                   input int mn, input int mx);
    return (mn >= 0) && (mn < mx) && (mx <= (1 << width) - 1) &&
           ((1 << step_w) - 1 <= range_of(mn, mx));
  endfunction

endpackage

// File: rtl/counter_gen_next.sv
// counter_gen_next: next-count computation for one step in the selected boundary mode.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is taken.
//
// Ports: count/step/dir_eff/mode in; next_count, evt (bound hit or crossed),
// flip_toggle (bounce reversal) out. A zero step yields count unchanged, no event.
module counter_gen_next
  import counter_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int MIN    = 0,
  parameter int MAX    = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [STEP_W-1:0] step,
  input  logic              dir_eff,
  input  mode_t             mode,
  output logic [WIDTH-1:0]  next_count,
  output logic              evt,
  output logic              flip_toggle
);

  localparam int SW = WIDTH + ARITH_GUARD;
  localparam logic signed [SW-1:0] MIN_S = SW'(MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX);
  localparam logic signed [SW-1:0] RNG_S = SW'(range_of(MIN, MAX));

  logic signed [SW-1:0] cnt_s;
  logic signed [SW-1:0] step_s;
  logic signed [SW-1:0] t;

  always_comb begin
    cnt_s       = signed'(SW'(count));
    step_s      = signed'(SW'(step));
    t           = dir_eff ? (cnt_s - step_s) : (cnt_s + step_s);
    next_count  = count;
    evt         = 1'b0;
    flip_toggle = 1'b0;

    if (step != '0) begin
      next_count = WIDTH'(t);
      case (mode)
        MODE_WRAP: begin
          // Landing exactly on a bound is not a crossing in wrap mode.
          if (t > MAX_S) begin
            next_count = WIDTH'(t - RNG_S);
            evt        = 1'b1;
          end else if (t < MIN_S) begin
            next_count = WIDTH'(t + RNG_S);
            evt        = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          if (t >= MAX_S) begin
            next_count  = WIDTH'(MAX_S);
            evt         = 1'b1;
            flip_toggle = 1'b1;
          end else if (t <= MIN_S) begin
            next_count  = WIDTH'(MIN_S);
            evt         = 1'b1;
            flip_toggle = 1'b1;
          end
        end
        default: begin
          // MODE_SAT and MODE_RSVD: clamp; sitting on a bound and pushing
          // outward re-fires the event every update.
          if (t >= MAX_S) begin
            next_count = WIDTH'(MAX_S);
            evt        = 1'b1;
          end else if (t <= MIN_S) begin
            next_count = WIDTH'(MIN_S);
            evt        = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_gen.sv
// counter_gen: up/down counter with run-time step, programmable bounds and wrap/sat/bounce modes.
// Latency: one clk_2 cycle from input sampling to count/bnd_evt/ovf update.
// Backpressure: en=0 (or step=0) freezes all state; there is no ready/handshake.
//
// Ports: clk_2, reset_n (async, active-low); controls en, clr, load, load_val,
// dn, step, mode; outputs count, dir_eff, at_min, at_max, bnd_evt, ovf.
module counter_gen
  import counter_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4,
  parameter int MIN    = 0,
  parameter int MAX    = (1 << WIDTH) - 1
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dn,
  input  logic [STEP_W-1:0] step,
  input  mode_t             mode,
  output logic [WIDTH-1:0]  count,
  output logic              dir_eff,
  output logic              at_min,
  output logic              at_max,
  output logic              bnd_evt,
  output logic              ovf
);

  if (!bounds_ok(WIDTH, STEP_W, MIN, MAX)) begin : g_param_err
    $fatal(1, "counter_gen: illegal WIDTH/STEP_W/MIN/MAX combination");
  end

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             flip_q, flip_d;
  logic             bnd_evt_q, bnd_evt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] nxt_count;
  logic             nxt_evt;
  logic             nxt_flip_toggle;
  logic [WIDTH-1:0] load_clamped;

  assign dir_eff = dn ^ flip_q;

  counter_gen_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MIN    (MIN),
    .MAX    (MAX)
  ) u_next (
    .count       (count_q),
    .step        (step),
    .dir_eff     (dir_eff),
    .mode        (mode),
    .next_count  (nxt_count),
    .evt         (nxt_evt),
    .flip_toggle (nxt_flip_toggle)
  );

  // Compare as int so the clamp stays meaningful when a bound sits at the
  // edge of the WIDTH-bit range.
  always_comb begin
    load_clamped = load_val;
    if (int'(load_val) < MIN)      load_clamped = MIN_W;
    else if (int'(load_val) > MAX) load_clamped = MAX_W;
  end

  always_comb begin
    count_d   = count_q;
    flip_d    = flip_q;
    bnd_evt_d = 1'b0;
    ovf_d     = ovf_q;

    if (clr) begin
      count_d = MIN_W;
      flip_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (en && (step != '0)) begin
      count_d   = nxt_count;
      // flip only lives in bounce mode; any other mode drops it on update.
      flip_d    = (mode == MODE_BOUNCE) ? (flip_q ^ nxt_flip_toggle) : 1'b0;
      bnd_evt_d = nxt_evt;
      ovf_d     = ovf_q | nxt_evt;
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= MIN_W;
      flip_q    <= 1'b0;
      bnd_evt_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      flip_q    <= flip_d;
      bnd_evt_q <= bnd_evt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count   = count_q;
  assign bnd_evt = bnd_evt_q;
  assign ovf     = ovf_q;
  assign at_min  = (count_q == MIN_W);
  assign at_max  = (count_q == MAX_W);

endmodule

// File: doc/counter_gen.md
# counter_gen

Parametrised up/down counter: the next generation of the board's switch-driven 4-bit counter. It adds configurable width, run-time step size and programmable bounds. It supports three boundary modes (wrap, saturate, bounce), synchronous load and clear, a one-cycle boundary-event pulse and a sticky overflow flag. It sits behind the board switches and drives LCD/LED display fields in the top-level, and it is also reusable as a timer or address generator inside larger blocks.

## Interface
- WIDTH, 8, counter width in bits
- STEP_W, 4, width of the step input
- MIN, 0, lower bound, inclusive
- MAX, 2**WIDTH-1, upper bound, inclusive
- Elaboration check: MIN < MAX <= 2**WIDTH-1, and 2**STEP_W-1 <= MAX-MIN+1; violation is a fatal error.

Ports:
- clk_2  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  count enable; 0 freezes the count
- clr  in  1  synchronous clear to MIN
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value to load
- dn  in  1  direction: 0 up, 1 down
- step  in  STEP_W  increment magnitude; 0 holds the count
- mode  in  2  boundary mode (mode_t)
- count  out  WIDTH  current value
- dir_eff  out  1  effective direction after any bounce flip
- at_min, at_max  out  1  count == MIN or count == MAX
- bnd_evt  out  1  one-cycle pulse: the last update crossed or hit a bound
- ovf  out  1  sticky: set on any bound event, cleared by clr or reset

## Operation
- Per-cycle priority: reset_n low, then clr, then load, then en==0 (hold), then step update.
- clr: count=MIN, flip=0, ovf=0, bnd_evt=0.
- load: count = load_val clamped into [MIN,MAX]. flip is unchanged. No event.
- en==0: all state holds and bnd_evt=0. A step of 0 has the same effect and raises no event.
- Step arithmetic uses WIDTH+2 bit signed math: t = count ± step, where the sign comes from dir_eff.
- dir_eff = dn XOR flip. flip is an internal register and can be 1 only in MODE_BOUNCE.
- MODE_WRAP (0): modular arithmetic on range R = MAX-MIN+1.
  - t > MAX gives count = t - R.
  - t < MIN gives count = t + R.
  - A crossing raises bnd_evt and ovf.
- MODE_SAT (1): t is clamped to MAX or MIN.
  - Clamping raises bnd_evt and ovf.
  - Once at a bound, further steps outward hold and re-pulse bnd_evt each cycle.
- MODE_BOUNCE (2): t is clamped to the bound and flip toggles, so the next step moves inward. This raises bnd_evt and ovf.
- Mode 3 is reserved and behaves as MODE_SAT.
- A mode change takes effect on the next update. Leaving BOUNCE clears flip on that update.
- Landing exactly on a bound without crossing it: bnd_evt fires in SAT and BOUNCE only, and BOUNCE also flips. In WRAP there is no event.

## Timing
- All outputs are registered except at_min, at_max and dir_eff, which decode registered state combinationally.
- Latency is one clock from input sampling to the count update.
- Reset values: count=MIN, flip=0, dir_eff=dn, bnd_evt=0, ovf=0, at_min=1, at_max=(MIN==MAX ? 1 : 0) (always 0 given the check).
- reset_n is asserted asynchronously and must be released synchronously to clk_2 by the top-level.
- Reset asserted mid-count forces reset values immediately, regardless of the other inputs.
- clr and load asserted together: clr wins.
- bnd_evt is high for exactly one cycle per qualifying update.
- ovf stays set until clr or reset, even across load.

## Structure
- Package counter_gen_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_WRAP, MODE_SAT, MODE_BOUNCE, MODE_RSVD}
  - shared localparam helpers for range computation
- Sub-module counter_gen_next is purely combinational. Given count, step, dir_eff and mode, it returns next_count, evt and flip_toggle.
- The top module holds the registers (count, flip, bnd_evt, ovf) and the priority logic.

## Test plan
All scenarios use WIDTH=4, STEP_W=2, MIN=0, MAX=15 unless noted.
- Reset: reset_n low mid-count at count=9 → count=0, ovf=0, bnd_evt=0 without waiting for a clock edge; release → count holds at 0 until en.
- Wrap: load 14, mode WRAP, up, step 3 → count 1, bnd_evt pulse, ovf=1. Then down, step 3 from 1 → 14, second pulse.
- Saturate: load 14, mode SAT, up, step 3 → 15 and pulse. Next cycle → 15 with another pulse. Then down, step 1 → 14, no pulse.
- Bounce: load 14, mode BOUNCE, dn=0, step 3 → 15 with dir_eff=1. Next cycles → 12, 9, 6, 3, 0 (pulse, dir_eff=0), then 3.
- Priority: clr=load=1 with en=0 and count=7 → count=0, ovf cleared. Then load_val=7 with load=1, en=0 → count 7. Then en=0 with step=3 → count stays 7.
- Bounds: instance with MIN=3, MAX=12, WIDTH=4. Load 15 → count 12. WRAP up step 2 → 4, pulse. Load 0 → 3.
